uart_rx_fifo: RTL and testbench

- Receive-side buffer directly downstream of the async serial UART receiver, in the UART's rx_clk domain.
- Detects a waiting character (uart_rx_empty low) and drives the UART's four-phase req/ack unload handshake.
- Captures each character and pushes it into a power-of-two FIFO.
- The CPU/IOT side drains the FIFO with single-cycle pop strobes, so bursts of input survive slow software polling.

---
 rtl/uart_rx_fifo_if.sv | 25 ++
 rtl/uart_rx_fifo.sv | 89 ++++++++
 tb/tb_uart_rx_fifo.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_fifo_if.sv
// Signal bundle between the UART receiver, the receive FIFO and the CPU-side reader.
// The FIFO uses the slave modport; the UART/CPU side (or a bench) uses master.
interface uart_rx_fifo_if #(
    parameter int unsigned DEPTH_LOG2 = 4
);
    logic                  uart_rx_empty;
    logic                  uart_rx_req;
    logic                  uart_rx_ack;
    logic [7:0]            uart_rx_data;
    logic                  rd_req;
    logic [7:0]            rd_data;
    logic                  fifo_empty;
    logic                  fifo_full;
    logic [DEPTH_LOG2:0]   fifo_count;

    modport slave (
        input  uart_rx_empty, uart_rx_ack, uart_rx_data, rd_req,
        output uart_rx_req, rd_data, fifo_empty, fifo_full, fifo_count
    );

    modport master (
        output uart_rx_empty, uart_rx_ack, uart_rx_data, rd_req,
        input  uart_rx_req, rd_data, fifo_empty, fifo_full, fifo_count
    );
endinterface

// File: rtl/uart_rx_fifo.sv
// Unloads characters from the UART receiver with a four-phase req/ack handshake
// and buffers them in a power-of-two show-ahead FIFO drained by single-cycle pops.
module uart_rx_fifo #(
    parameter int unsigned DEPTH_LOG2 = 4
) (
    input  logic           rx_clk,
    input  logic           reset,
    uart_rx_fifo_if.slave  bus
);
    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        CAPT = 2'd2,
        DROP = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic                  req_q;
    logic [7:0]            mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_q, rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2:0]   count_q, count_d;
    logic [7:0]            head_q;
    logic                  fifo_empty, fifo_full;
    logic                  push, pop;

    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == (DEPTH_LOG2+1)'(DEPTH));
    assign push       = (state_q == CAPT);
    assign pop        = bus.rd_req && !fifo_empty;

    always_ff @(posedge rx_clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = IDLE;
        unique case (state_q)
            IDLE:    state_d = (!bus.uart_rx_empty && !fifo_full) ? REQ : IDLE;
            REQ:     state_d = bus.uart_rx_ack ? CAPT : REQ;
            CAPT:    state_d = DROP;
            DROP:    state_d = bus.uart_rx_ack ? DROP : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        rd_ptr_d = pop ? rd_ptr_q + DEPTH_LOG2'(1) : rd_ptr_q;
        count_d  = count_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + (DEPTH_LOG2+1)'(1);
            2'b01:   count_d = count_q - (DEPTH_LOG2+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge rx_clk) begin
        if (push) mem[wr_ptr_q] <= bus.uart_rx_data;
    end

    // Head register is preloaded with the entry rd_ptr will point at next edge;
    // a write landing on that slot this same edge is forwarded directly.
    always_ff @(posedge rx_clk or posedge reset) begin
        if (reset) begin
            req_q    <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            head_q   <= '0;
        end else begin
            req_q    <= (state_d == REQ);
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            if (push) wr_ptr_q <= wr_ptr_q + DEPTH_LOG2'(1);
            if (count_d != '0) begin
                if (push && (wr_ptr_q == rd_ptr_d)) head_q <= bus.uart_rx_data;
                else                                head_q <= mem[rd_ptr_d];
            end
        end
    end

    assign bus.uart_rx_req = req_q;
    assign bus.rd_data     = head_q;
    assign bus.fifo_empty  = fifo_empty;
    assign bus.fifo_full   = fifo_full;
    assign bus.fifo_count  = count_q;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: UART handshake model, scoreboard of expected
// characters, CPU-side pops checked against the scoreboard head.
module tb_uart_rx_fifo;
    logic clk;
    logic reset;
    int unsigned checks;
    int unsigned errors;
    logic [7:0] exp_q[$];

    uart_rx_fifo_if #(.DEPTH_LOG2(4)) bif ();

    uart_rx_fifo #(.DEPTH_LOG2(4)) dut (
        .rx_clk (clk),
        .reset  (reset),
        .bus    (bif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic offer(input logic [7:0] c);
        bif.uart_rx_empty = 1'b0;
        bif.uart_rx_data  = c;
    endtask

    task automatic wait_req();
        int unsigned n = 0;
        while (bif.uart_rx_req !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("req_rise", {31'd0, bif.uart_rx_req}, 32'd1);
    endtask

    // Completes the handshake from REQ; ends with the FSM back in IDLE.
    task automatic handshake(input logic [7:0] c);
        bif.uart_rx_ack   = 1'b1;
        bif.uart_rx_empty = 1'b1;
        @(negedge clk);
        chk("req_low_capt", {31'd0, bif.uart_rx_req}, 32'd0);
        bif.uart_rx_ack = 1'b0;
        @(negedge clk);
        @(negedge clk);
        exp_q.push_back(c);
    endtask

    task automatic send_char(input logic [7:0] c);
        offer(c);
        @(negedge clk);
        wait_req();
        handshake(c);
    endtask

    task automatic pop_chk(input string tag);
        logic [7:0] e;
        if (exp_q.size() == 0) begin
            chk({tag, "_sb_empty"}, 32'd1, 32'd0);
        end else begin
            e = exp_q.pop_front();
            chk(tag, {24'd0, bif.rd_data}, {24'd0, e});
        end
        bif.rd_req = 1'b1;
        @(negedge clk);
        bif.rd_req = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        bif.uart_rx_empty = 1'b1;
        bif.uart_rx_ack   = 1'b0;
        bif.uart_rx_data  = 8'h00;
        bif.rd_req        = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_req",   {31'd0, bif.uart_rx_req}, 32'd0);
        chk("rst_empty", {31'd0, bif.fifo_empty},  32'd1);
        chk("rst_full",  {31'd0, bif.fifo_full},   32'd0);
        chk("rst_count", {27'd0, bif.fifo_count},  32'd0);
        chk("rst_data",  {24'd0, bif.rd_data},     32'd0);
        reset = 1'b0;
        @(negedge clk);

        // Single character: req one cycle after the offer, visible after capture.
        offer(8'h41);
        @(negedge clk);
        chk("t1_req_1cyc", {31'd0, bif.uart_rx_req}, 32'd1);
        handshake(8'h41);
        chk("t1_count", {27'd0, bif.fifo_count}, 32'd1);
        chk("t1_empty", {31'd0, bif.fifo_empty}, 32'd0);
        chk("t1_req_idle", {31'd0, bif.uart_rx_req}, 32'd0);
        pop_chk("t1_data");
        chk("t1_empty_after", {31'd0, bif.fifo_empty}, 32'd1);

        // Three characters then drain, plus a pop on empty.
        send_char(8'h01);
        send_char(8'h02);
        send_char(8'h03);
        chk("t2_count3", {27'd0, bif.fifo_count}, 32'd3);
        repeat (3) pop_chk("t2_data");
        chk("t2_empty", {31'd0, bif.fifo_empty}, 32'd1);
        chk("t2_count0", {27'd0, bif.fifo_count}, 32'd0);
        bif.rd_req = 1'b1;
        @(negedge clk);
        bif.rd_req = 1'b0;
        chk("t2_underflow_count", {27'd0, bif.fifo_count}, 32'd0);
        chk("t2_underflow_empty", {31'd0, bif.fifo_empty}, 32'd1);
        send_char(8'h5A);
        pop_chk("t2_after_underflow");

        // Fill to 16, a 17th waits in the UART until a slot frees.
        for (int i = 0; i < 16; i++) send_char(8'h80 + 8'(i));
        chk("t3_full", {31'd0, bif.fifo_full}, 32'd1);
        chk("t3_count16", {27'd0, bif.fifo_count}, 32'd16);
        offer(8'hEE);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("t3_req_held", {31'd0, bif.uart_rx_req}, 32'd0);
        end
        pop_chk("t3_pop_full");
        chk("t3_not_full", {31'd0, bif.fifo_full}, 32'd0);
        wait_req();
        handshake(8'hEE);
        chk("t3_refull_count", {27'd0, bif.fifo_count}, 32'd16);
        chk("t3_refull", {31'd0, bif.fifo_full}, 32'd1);
        repeat (16) pop_chk("t3_drain");
        chk("t3_drained", {31'd0, bif.fifo_empty}, 32'd1);

        // Pop during CAPT with one entry held.
        send_char(8'h11);
        offer(8'h22);
        @(negedge clk);
        wait_req();
        bif.uart_rx_ack   = 1'b1;
        bif.uart_rx_empty = 1'b1;
        @(negedge clk);
        bif.uart_rx_ack = 1'b0;
        bif.rd_req      = 1'b1;
        chk("t4_old_head", {24'd0, bif.rd_data}, {24'd0, exp_q.pop_front()});
        @(negedge clk);
        bif.rd_req = 1'b0;
        exp_q.push_back(8'h22);
        chk("t4_count", {27'd0, bif.fifo_count}, 32'd1);
        @(negedge clk);
        pop_chk("t4_new_head");

        // Wrap: push/pop pairs, occupancy never above one.
        for (int i = 0; i < 40; i++) begin
            send_char(8'(i + 8'h30));
            chk("t5_count1", {27'd0, bif.fifo_count}, 32'd1);
            pop_chk("t5_data");
        end
        chk("t5_empty", {31'd0, bif.fifo_empty}, 32'd1);

        // Reset while in REQ.
        send_char(8'h55);
        offer(8'h66);
        @(negedge clk);
        wait_req();
        reset = 1'b1;
        bif.uart_rx_empty = 1'b1;
        bif.uart_rx_ack   = 1'b0;
        #1;
        chk("t6_req_rst_req",   {31'd0, bif.uart_rx_req}, 32'd0);
        chk("t6_req_rst_count", {27'd0, bif.fifo_count},  32'd0);
        chk("t6_req_rst_empty", {31'd0, bif.fifo_empty},  32'd1);
        chk("t6_req_rst_data",  {24'd0, bif.rd_data},     32'd0);
        exp_q.delete();
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        send_char(8'h77);
        pop_chk("t6_resume1");

        // Reset while in DROP (ack still high).
        offer(8'h88);
        @(negedge clk);
        wait_req();
        bif.uart_rx_ack   = 1'b1;
        bif.uart_rx_empty = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("t6_drop_count_pre", {27'd0, bif.fifo_count}, 32'd1);
        reset = 1'b1;
        bif.uart_rx_ack = 1'b0;
        #1;
        chk("t6_drop_rst_req",   {31'd0, bif.uart_rx_req}, 32'd0);
        chk("t6_drop_rst_count", {27'd0, bif.fifo_count},  32'd0);
        chk("t6_drop_rst_empty", {31'd0, bif.fifo_empty},  32'd1);
        exp_q.delete();
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        send_char(8'h99);
        pop_chk("t6_resume2");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
